// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI slave interface.
//   Opcode constants carried in the top two bits of every received frame,
//   the receive/transmit FSM state type, and the default frame/response widths.
package spi_pkg;

    localparam int DEF_FRAME_W = 18;
    localparam int DEF_TX_W    = 16;

    localparam logic [1:0] ADDR_STORE = 2'b00;
    localparam logic [1:0] DATA_WRITE = 2'b01;
    localparam logic [1:0] READ_ADDR  = 2'b10;
    localparam logic [1:0] READ_DATA  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX      = 2'd1,
        WAIT_TX = 2'd2,
        TX      = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge -- multi-flop synchronizer with edge detection.
//   sys_clock : system clock (rising edge)
//   reset_n   : asynchronous active-low reset; all flops load RST_VAL
//   din       : asynchronous input
//   sync      : synchronized level
//   rise/fall : single-cycle strobes on synchronized 0->1 / 1->0 transitions
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clock,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if -- SPI mode-0 slave front end between an SPI master and a memory stage.
//   sys_clock, reset_n : system clock, asynchronous active-low reset
//   sclk, ss_n, mosi   : asynchronous SPI inputs (synchronized internally)
//   miso               : response data, MSB first, 0 outside response transfer
//   rx_data/rx_valid   : completed frame and its one-cycle strobe
//   tx_data/tx_valid   : read response from memory stage, low TX_W bits used
//   busy               : FSM not idle
//   frame_err          : only when SPI_SLAVE_FRAME_ERR_EN is defined; pulses when
//                        ss_n deasserts in the middle of a frame or response
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W     = DEF_FRAME_W,
    parameter int TX_W        = DEF_TX_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               sys_clock,
    input  logic               reset_n,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_valid,
    output logic               busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic               frame_err
`endif
);

    localparam int MAX_W = (FRAME_W > TX_W) ? FRAME_W : TX_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_W - 1);

    spi_state_t state, state_nxt;

    logic sclk_rise, sclk_fall, unused_sclk_s;
    logic ss_n_s, ss_rise, unused_ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-2:0] shift;
    logic [TX_W-1:0]    tx_sr;
    logic [FRAME_W-1:0] frame_word;
    logic               frame_done, tx_done;

    // After reset the ss_n synchronizer holds its idle value, not the pin.
    // settle_pipe waits until the chain has flushed; armed then requires ss_n
    // to be seen high, so a select held low across reset cannot start a frame.
    logic [SYNC_STAGES:0] settle_pipe;
    logic                 armed;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .din       (sclk),
        .sync      (unused_sclk_s),
        .rise      (sclk_rise),
        .fall      (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .din       (ss_n),
        .sync      (ss_n_s),
        .rise      (ss_rise),
        .fall      (unused_ss_fall)
    );

    // Same depth as the sclk chain so mosi lines up with the detected edge.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) mosi_sync[i] <= mosi_sync[i-1];
        end
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            settle_pipe <= '0;
            armed       <= 1'b0;
        end else begin
            settle_pipe <= {settle_pipe[SYNC_STAGES-1:0], 1'b1};
            armed       <= armed | (settle_pipe[SYNC_STAGES] & ss_n_s);
        end
    end

    assign frame_word = {shift, mosi_s};
    // ss_n rising always wins over a coincident final edge.
    assign frame_done = (state == RX) && sclk_rise && (cnt == RX_LAST) && !ss_rise;
    assign tx_done    = (state == TX) && sclk_rise && (cnt == TX_LAST) && !ss_rise;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed && !ss_n_s) state_nxt = RX;
            RX:      if (frame_done && frame_word[FRAME_W-1 -: 2] == READ_DATA) state_nxt = WAIT_TX;
            WAIT_TX: if (tx_valid) state_nxt = TX;
            TX:      if (tx_done) state_nxt = RX;
            default: state_nxt = IDLE;
        endcase
        if (ss_rise) state_nxt = IDLE;
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            shift    <= '0;
            tx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= frame_done;
            if (frame_done) rx_data <= frame_word;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    shift <= '0;
                    tx_sr <= '0;
                end
                RX: begin
                    if (sclk_rise) begin
                        if (cnt == RX_LAST) begin
                            cnt   <= '0;
                            shift <= '0;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            shift <= frame_word[FRAME_W-2:0];
                        end
                    end
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        tx_sr <= tx_data[TX_W-1:0];
                        cnt   <= '0;
                    end
                end
                TX: begin
                    // Falling edge presents the next bit; rising edge is the
                    // master's sample point and is what gets counted.
                    if (sclk_fall) tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
                    if (sclk_rise) begin
                        if (cnt == TX_LAST) begin
                            cnt   <= '0;
                            tx_sr <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
            if (ss_rise) begin
                cnt   <= '0;
                shift <= '0;
                tx_sr <= '0;
            end
        end
    end

    assign miso = (state == TX) ? tx_sr[TX_W-1] : 1'b0;
    assign busy = (state != IDLE);

    generate
        if (FRAME_W > TX_W) begin : g_tx_hi
            logic unused_tx_hi;
            assign unused_tx_hi = ^tx_data[FRAME_W-1:TX_W];
        end
    endgenerate

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) frame_err <= 1'b0;
        else          frame_err <= ss_rise && (((state == RX) && (cnt != '0)) ||
                                               (state == WAIT_TX) || (state == TX));
    end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if -- directed and randomized bench for spi_slave_if.
//   Acts as the SPI master (mode 0) and the memory stage. Expected frames and
//   read responses come from a queue model: every frame clocked in completely
//   inside an ss_n window is expected on rx_data in order; aborted frames are
//   not; every read response is expected back on miso as tx_data[15:0].
module tb_spi_slave_if;

    localparam int HP = 6;  // sclk half period in sys_clock cycles

    logic        sys_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic        sclk      = 1'b0;
    logic        ss_n      = 1'b1;
    logic        mosi      = 1'b0;
    logic        miso;
    logic [17:0] rx_data;
    logic        rx_valid;
    logic [17:0] tx_data   = '0;
    logic        tx_valid  = 1'b0;
    logic        busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err;
    int          err_cnt = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [17:0] rx_q[$];
    logic [17:0] exp_q[$];

    spi_slave_if dut (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .busy      (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 sys_clock = ~sys_clock;

    always @(negedge sys_clock) begin
        if (rx_valid) rx_q.push_back(rx_data);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) err_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_rx(input string tag);
        check({tag, "_cnt"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            cycles(HP);
            sclk = 1'b1;
            cycles(HP);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [17:0] f);
        send_bits(32'(f), 18);
        exp_q.push_back(f);
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
        cycles(4);
    endtask

    task automatic ss_end();
        cycles(HP);
        ss_n = 1'b1;
        cycles(6);
    endtask

    // Memory stage answers after 'dly' cycles, then master clocks 16 bits out.
    task automatic serve_read(input logic [17:0] td, input int dly, output logic [15:0] w);
        cycles(dly);
        check("miso_wait_tx", 32'(miso), 0);
        tx_data  = td;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
        tx_data  = 18'($urandom);
        w = '0;
        for (int i = 15; i >= 0; i--) begin
            mosi = 1'($urandom_range(0, 1));
            cycles(HP);
            w[i] = miso;
            sclk = 1'b1;
            cycles(HP);
            sclk = 1'b0;
        end
        cycles(HP);
    endtask

    initial begin
        logic [15:0] word;
        logic [17:0] f, td;
        int          nf, nb;
        bit          abort;
        int          exp_err;

        // reset state
        cycles(3);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_miso", 32'(miso), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        cycles(10);
        check("idle_busy", 32'(busy), 0);

        // single ADDR_STORE frame
        ss_begin();
        check("ss_low_busy", 32'(busy), 1);
        send_frame(18'h0_0055);
        cycles(HP);
        check("addr_miso", 32'(miso), 0);
        check("addr_busy_rx", 32'(busy), 1);
        ss_end();
        check("addr_end_busy", 32'(busy), 0);
        cmp_rx("addr");

        // back-to-back frames in one window
        ss_begin();
        send_frame(18'h0_0055);
        send_frame(18'h1_A5A5);
        ss_end();
        cmp_rx("b2b");

        // READ_DATA with response, then a further frame in the same window
`ifdef SPI_SLAVE_FRAME_ERR_EN
        err_cnt = 0;
`endif
        ss_begin();
        send_frame(18'h3_0000);
        serve_read(18'h0BEEF, 5, word);
        check("read_word", 32'(word), 32'h0000BEEF);
        check("read_miso_after", 32'(miso), 0);
        check("read_busy_rx", 32'(busy), 1);
        send_frame(18'h0_1234);
        ss_end();
        cmp_rx("read");
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("read_frame_err", err_cnt, 0);
`endif

        // ss_n raised after 9 bits
`ifdef SPI_SLAVE_FRAME_ERR_EN
        err_cnt = 0;
`endif
        ss_begin();
        send_bits(32'h1FF, 9);
        ss_end();
        check("abort9_busy", 32'(busy), 0);
        cmp_rx("abort9");
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort9_frame_err", err_cnt, 1);
`endif

        // ss_n rise coincident with the last sclk rise
        ss_begin();
        send_bits(32'h1_5555 >> 1, 17);
        mosi = 1'b1;
        cycles(HP);
        sclk = 1'b1;
        ss_n = 1'b1;
        cycles(HP);
        sclk = 1'b0;
        cycles(6);
        check("coinc_busy", 32'(busy), 0);
        cmp_rx("coinc");

        // reset mid-frame with ss_n held low
        ss_begin();
        send_bits(32'h2AA, 10);
        reset_n = 1'b0;
        cycles(2);
        check("mrst_rx_data", 32'(rx_data), 0);
        check("mrst_rx_valid", 32'(rx_valid), 0);
        check("mrst_miso", 32'(miso), 0);
        check("mrst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        send_bits(32'hFF, 8);
        cycles(HP);
        check("mrst_no_start", 32'(busy), 0);
        cmp_rx("mrst_tail");
        ss_n = 1'b1;
        cycles(6);
        ss_begin();
        send_frame(18'h2_0123);
        ss_end();
        cmp_rx("mrst_new");

        // tx_valid in RX is ignored
        ss_begin();
        send_bits(32'h1_2345 >> 13, 5);
        tx_data  = 18'h3FFFF;
        tx_valid = 1'b1;
        cycles(2);
        check("txv_rx_miso", 32'(miso), 0);
        tx_valid = 1'b0;
        send_bits(32'h1_2345, 13);
        exp_q.push_back(18'h1_2345);
        cycles(HP);
        check("txv_rx_busy", 32'(busy), 1);
        ss_end();
        cmp_rx("txv_rx");

        // randomized windows against the queue model
        for (int w = 0; w < 6; w++) begin
            exp_err = 0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            err_cnt = 0;
`endif
            nf = $urandom_range(1, 3);
            ss_begin();
            for (int k = 0; k < nf; k++) begin
                f = {2'($urandom_range(0, 2)), 16'($urandom)};
                if ($urandom_range(0, 2) == 0) f[17:16] = 2'b11;
                send_frame(f);
                if (f[17:16] == 2'b11) begin
                    td = 18'($urandom);
                    serve_read(td, $urandom_range(5, 12), word);
                    check($sformatf("rnd%0d_read%0d", w, k), 32'(word), 32'(td[15:0]));
                end
            end
            abort = ($urandom_range(0, 1) == 1);
            if (abort) begin
                nb = $urandom_range(1, 17);
                send_bits($urandom, nb);
                exp_err = 1;
            end
            ss_end();
            check($sformatf("rnd%0d_busy", w), 32'(busy), 0);
            cmp_rx($sformatf("rnd%0d", w));
`ifdef SPI_SLAVE_FRAME_ERR_EN
            check($sformatf("rnd%0d_frame_err", w), err_cnt, exp_err);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
